// File: rtl/reg_shadow_err_collect.sv
// Sticky error collector for shadowed-register err_update/err_storage with a
// four-phase recoverable alert and level fatal alert. Macro REG_SHADOW_ERR_CNT_EN adds an update-error counter.
//
// state      | meaning
// StIdle     | no recoverable alert outstanding
// StReq      | req high, waiting for ack to rise
// StWaitAckLow | req low, waiting for ack to fall
module reg_shadow_err_collect #(
    parameter int NumRegs = 8,
    parameter int IdxW    = (NumRegs > 1) ? $clog2(NumRegs) : 1,
    parameter int CntW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumRegs-1:0] err_update_i,
    input  logic [NumRegs-1:0] err_storage_i,
    input  logic               clr_we_i,
    input  logic [NumRegs-1:0] clr_wd_i,
    output logic [NumRegs-1:0] update_status_o,
    output logic [NumRegs-1:0] storage_status_o,
    output logic               first_valid_o,
    output logic [IdxW-1:0]    first_idx_o,
    output logic               recov_alert_req_o,
    input  logic               recov_alert_ack_i,
    output logic               fatal_alert_o,
    output logic [CntW-1:0]    err_cnt_o
);

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StReq        = 2'd1,
        StWaitAckLow = 2'd2
    } state_e;

    state_e             state_q;
    logic               pending_q;
    logic               new_recov;
    logic [NumRegs-1:0] clr_mask;
    logic [NumRegs-1:0] update_d;
    logic [NumRegs-1:0] storage_d;
    logic [NumRegs-1:0] any_err;
    logic [IdxW-1:0]    low_idx;

    assign new_recov = |err_update_i;

    always_comb begin
        clr_mask  = clr_we_i ? clr_wd_i : '0;
        update_d  = (update_status_o & ~clr_mask) | err_update_i;
        storage_d = storage_status_o | err_storage_i;
        any_err   = err_update_i | err_storage_i;
        low_idx   = '0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = NumRegs - 1; i >= 0; i--) begin
            if (any_err[i]) begin
                low_idx = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_status_o  <= '0;
            storage_status_o <= '0;
            fatal_alert_o    <= 1'b0;
        end else begin
            update_status_o  <= update_d;
            storage_status_o <= storage_d;
            fatal_alert_o    <= |storage_d;
        end
    end

    // Capture is only released once a SW clear leaves nothing sticky behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_valid_o <= 1'b0;
            first_idx_o   <= '0;
        end else if (!first_valid_o && (|any_err)) begin
            first_valid_o <= 1'b1;
            first_idx_o   <= low_idx;
        end else if (first_valid_o && clr_we_i && (update_d == '0) && (storage_d == '0)) begin
            first_valid_o <= 1'b0;
            first_idx_o   <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= StIdle;
            pending_q         <= 1'b0;
            recov_alert_req_o <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (new_recov || pending_q) begin
                        state_q           <= StReq;
                        pending_q         <= 1'b0;
                        recov_alert_req_o <= 1'b1;
                    end
                end
                StReq: begin
                    if (new_recov) begin
                        pending_q <= 1'b1;
                    end
                    if (recov_alert_ack_i) begin
                        state_q           <= StWaitAckLow;
                        recov_alert_req_o <= 1'b0;
                    end
                end
                StWaitAckLow: begin
                    if (new_recov) begin
                        pending_q <= 1'b1;
                    end
                    if (!recov_alert_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q           <= StIdle;
                    recov_alert_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_SHADOW_ERR_CNT_EN
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (new_recov && (cnt_q != {CntW{1'b1}})) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign err_cnt_o = cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reg_shadow_err_collect.sv
// Directed self-checking bench for reg_shadow_err_collect (NumRegs=8).
// Counter expectations follow REG_SHADOW_ERR_CNT_EN as defined for the build.
module tb_reg_shadow_err_collect;

`ifdef REG_SHADOW_ERR_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 8;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [7:0]    err_update_i = '0;
    logic [7:0]    err_storage_i = '0;
    logic          clr_we_i = 1'b0;
    logic [7:0]    clr_wd_i = '0;
    logic [7:0]    update_status_o;
    logic [7:0]    storage_status_o;
    logic          first_valid_o;
    logic [2:0]    first_idx_o;
    logic          recov_alert_req_o;
    logic          recov_alert_ack_i = 1'b0;
    logic          fatal_alert_o;
    logic [CW-1:0] err_cnt_o;

    int total = 0;
    int bad = 0;

    reg_shadow_err_collect #(.NumRegs(8), .CntW(CW)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .err_update_i      (err_update_i),
        .err_storage_i     (err_storage_i),
        .clr_we_i          (clr_we_i),
        .clr_wd_i          (clr_wd_i),
        .update_status_o   (update_status_o),
        .storage_status_o  (storage_status_o),
        .first_valid_o     (first_valid_o),
        .first_idx_o       (first_idx_o),
        .recov_alert_req_o (recov_alert_req_o),
        .recov_alert_ack_i (recov_alert_ack_i),
        .fatal_alert_o     (fatal_alert_o),
        .err_cnt_o         (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        err_update_i = '0;
        err_storage_i = '0;
        clr_we_i = 1'b0;
        clr_wd_i = '0;
        recov_alert_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            recov_alert_ack_i = c[0];
            step();
            total++;
            if ({update_status_o, storage_status_o, first_valid_o, first_idx_o,
                 recov_alert_req_o, fatal_alert_o} !== 22'd0 || err_cnt_o !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d upd=%h sto=%h fv=%b fi=%0d req=%b fat=%b cnt=%0d expected all 0",
                         c, update_status_o, storage_status_o, first_valid_o, first_idx_o,
                         recov_alert_req_o, fatal_alert_o, err_cnt_o);
            end
        end
        recov_alert_ack_i = 1'b0;
    endtask

    task automatic test_single_alert();
        do_reset();
        err_update_i = 8'h04;
        step();
        err_update_i = '0;
        total++;
        if (update_status_o !== 8'h04 || first_idx_o !== 3'd2 || first_valid_o !== 1'b1
            || recov_alert_req_o !== 1'b1) begin
            bad++;
            $display("FAIL single_first upd=%h fi=%0d fv=%b req=%b expected 04 2 1 1",
                     update_status_o, first_idx_o, first_valid_o, recov_alert_req_o);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (recov_alert_req_o !== 1'b1) begin
                bad++;
                $display("FAIL single_hold cyc=%0d req=%b expected 1", c, recov_alert_req_o);
            end
        end
        recov_alert_ack_i = 1'b1;
        step();
        total++;
        if (recov_alert_req_o !== 1'b0) begin
            bad++;
            $display("FAIL single_ack req=%b expected 0", recov_alert_req_o);
        end
        recov_alert_ack_i = 1'b0;
        step();
        step();
        total++;
        if (recov_alert_req_o !== 1'b0) begin
            bad++;
            $display("FAIL single_idle req=%b expected 0", recov_alert_req_o);
        end
        clr_we_i = 1'b1;
        clr_wd_i = 8'h04;
        step();
        clr_we_i = 1'b0;
        clr_wd_i = '0;
        total++;
        if (update_status_o !== 8'h00 || first_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_clear upd=%h fv=%b expected 00 0", update_status_o, first_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int reqs;
        do_reset();
        err_update_i = 8'h04;
        step();
        err_update_i = 8'h01;
        step();
        err_update_i = 8'h80;
        step();
        err_update_i = '0;
        total++;
        if (update_status_o !== 8'h85 || recov_alert_req_o !== 1'b1 || first_idx_o !== 3'd2) begin
            bad++;
            $display("FAIL b2b_status upd=%h req=%b fi=%0d expected 85 1 2",
                     update_status_o, recov_alert_req_o, first_idx_o);
        end
        recov_alert_ack_i = 1'b1;
        step();
        recov_alert_ack_i = 1'b0;
        step();
        step();
        total++;
        if (recov_alert_req_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_req req=%b expected 1", recov_alert_req_o);
        end
        // Complete the second handshake and count any further requests.
        recov_alert_ack_i = 1'b1;
        step();
        recov_alert_ack_i = 1'b0;
        reqs = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (recov_alert_req_o === 1'b1) reqs++;
        end
        total++;
        if (reqs !== 0) begin
            bad++;
            $display("FAIL b2b_extra_req cycles_high=%0d expected 0", reqs);
        end
    endtask

    task automatic test_fatal();
        do_reset();
        err_storage_i = 8'h10;
        step();
        err_storage_i = '0;
        total++;
        if (fatal_alert_o !== 1'b1 || storage_status_o !== 8'h10 || first_idx_o !== 3'd4
            || first_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL fatal_set fat=%b sto=%h fi=%0d fv=%b expected 1 10 4 1",
                     fatal_alert_o, storage_status_o, first_idx_o, first_valid_o);
        end
        clr_we_i = 1'b1;
        clr_wd_i = 8'hFF;
        step();
        clr_we_i = 1'b0;
        clr_wd_i = '0;
        step();
        total++;
        if (fatal_alert_o !== 1'b1 || storage_status_o !== 8'h10 || first_valid_o !== 1'b1
            || recov_alert_req_o !== 1'b0) begin
            bad++;
            $display("FAIL fatal_noclr fat=%b sto=%h fv=%b req=%b expected 1 10 1 0",
                     fatal_alert_o, storage_status_o, first_valid_o, recov_alert_req_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (fatal_alert_o !== 1'b0 || storage_status_o !== 8'h00) begin
            bad++;
            $display("FAIL fatal_reset fat=%b sto=%h expected 0 00", fatal_alert_o, storage_status_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset_mid_handshake();
        int reqs;
        do_reset();
        err_update_i = 8'h02;
        step();
        err_update_i = 8'h08;
        step();
        err_update_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (recov_alert_req_o !== 1'b0 || update_status_o !== 8'h00) begin
            bad++;
            $display("FAIL midrst_async req=%b upd=%h expected 0 00", recov_alert_req_o, update_status_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (recov_alert_req_o === 1'b1) reqs++;
        end
        total++;
        if (reqs !== 0) begin
            bad++;
            $display("FAIL midrst_pending cycles_high=%0d expected 0", reqs);
        end
    endtask

    task automatic test_set_wins_and_lowest();
        do_reset();
        err_update_i = 8'h02;
        step();
        err_update_i = 8'h02;
        clr_we_i = 1'b1;
        clr_wd_i = 8'h02;
        step();
        err_update_i = '0;
        clr_we_i = 1'b0;
        clr_wd_i = '0;
        total++;
        if (update_status_o !== 8'h02 || first_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL set_wins upd=%h fv=%b expected 02 1", update_status_o, first_valid_o);
        end
        do_reset();
        err_update_i = 8'h48;
        step();
        err_update_i = 8'h01;
        total++;
        if (first_idx_o !== 3'd3 || first_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL lowest_idx fi=%0d fv=%b expected 3 1", first_idx_o, first_valid_o);
        end
        step();
        err_update_i = '0;
        total++;
        if (first_idx_o !== 3'd3 || update_status_o !== 8'h49) begin
            bad++;
            $display("FAIL no_overwrite fi=%0d upd=%h expected 3 49", first_idx_o, update_status_o);
        end
        // Clearing only part of the status must keep the capture.
        clr_we_i = 1'b1;
        clr_wd_i = 8'h08;
        step();
        clr_we_i = 1'b0;
        clr_wd_i = '0;
        total++;
        if (first_valid_o !== 1'b1 || update_status_o !== 8'h41) begin
            bad++;
            $display("FAIL partial_clr fv=%b upd=%h expected 1 41", first_valid_o, update_status_o);
        end
    endtask

    task automatic test_counter();
        logic [CW-1:0] exp10;
        logic [CW-1:0] exp20;
        logic [CW-1:0] exp1;
`ifdef REG_SHADOW_ERR_CNT_EN
        exp10 = 4'd10;
        exp20 = 4'd15;
        exp1  = 4'd1;
`else
        exp10 = '0;
        exp20 = '0;
        exp1  = '0;
`endif
        do_reset();
        for (int c = 0; c < 20; c++) begin
            err_update_i = 8'h01;
            step();
            err_update_i = '0;
            step();
            if (c == 9) begin
                total++;
                if (err_cnt_o !== exp10) begin
                    bad++;
                    $display("FAIL cnt_10 cnt=%0d expected %0d", err_cnt_o, exp10);
                end
            end
        end
        total++;
        if (err_cnt_o !== exp20) begin
            bad++;
            $display("FAIL cnt_sat cnt=%0d expected %0d", err_cnt_o, exp20);
        end
        do_reset();
        err_update_i = 8'hFF;
        step();
        err_update_i = '0;
        total++;
        if (err_cnt_o !== exp1) begin
            bad++;
            $display("FAIL cnt_multibit cnt=%0d expected %0d", err_cnt_o, exp1);
        end
    endtask

    initial begin
        test_reset();
        test_single_alert();
        test_back_to_back();
        test_fatal();
        test_reset_mid_handshake();
        test_set_wins_and_lowest();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_shadow_err_collect.md
Name: reg_shadow_err_collect

Overview:
Downstream collector for the err_update/err_storage outputs of a register file's shadowed subregisters. It latches per-register sticky status and classifies each error:
- update errors are recoverable, reported through a four-phase alert handshake;
- storage errors are fatal, reported through a level alert held until reset.
It sits between the register file and the alert sender and also exposes status for SW readback.

Parameters:
NumRegs, 8, number of shadowed registers monitored (1..32)
IdxW, $clog2(NumRegs) (min 1), width of first-error index
CntW, 8, width of saturating update-error counter (optional feature only)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
err_update_i  input  NumRegs  per-register err_update from shadowed subregs (pulse or level)
err_storage_i  input  NumRegs  per-register err_storage (level)
clr_we_i  input  1  SW write strobe to update-status clear register
clr_wd_i  input  NumRegs  W1C mask for update status
update_status_o  output  NumRegs  sticky recoverable-error bits
storage_status_o  output  NumRegs  sticky fatal-error bits
first_valid_o  output  1  first_idx_o holds a captured index
first_idx_o  output  IdxW  index of first register to raise any error since reset/clear
recov_alert_req_o  output  1  recoverable alert request
recov_alert_ack_i  input  1  recoverable alert acknowledge
fatal_alert_o  output  1  fatal alert level
err_cnt_o  output  CntW  saturating update-error count (0 when feature off)

Behaviour:
- Reset: all outputs 0; FSM in Idle; pending flag 0.
- update_status: per bit, next = (q & ~(clr_we_i ? clr_wd_i : 0)) | err_update_i. Set wins over a simultaneous clear of the same bit. Visible 1 cycle after input.
- storage_status: next = q | err_storage_i. There is no clear; only rst_ni clears it.
- fatal_alert_o: registered OR of storage_status next value. Asserts 1 cycle after any err_storage_i bit and stays high until reset.
- First-error capture:
  - When first_valid_o=0 and any error bit (update or storage) is set, capture the lowest set index and set first_valid_o next cycle.
  - Later errors do not overwrite the capture.
  - first_valid_o clears when a clr_we_i leaves all update_status bits 0 and storage_status is 0; capture can re-arm on the following error.
- new_recov = |err_update_i, sampled each cycle.
- Recoverable alert FSM, states Idle, Req, WaitAckLow:
  - Idle: if new_recov or pending, go to Req and clear pending. recov_alert_req_o=1 from the next cycle.
  - Req: hold req=1 until recov_alert_ack_i=1, then go to WaitAckLow with req=0.
  - WaitAckLow: hold req=0 until ack=0, then return to Idle.
  - new_recov in Req or WaitAckLow sets pending; multiple errors collapse into one extra alert.
  - new_recov in Idle while pending=1: a single alert covers both.
  - Protocol: req is never deasserted before ack is seen. ack=1 observed in Idle is ignored.
- Reset mid-handshake: req drops immediately (async); the FSM returns to Idle with no pending.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
REG_SHADOW_ERR_CNT_EN
- Defined: err_cnt_o increments by 1 on every cycle with new_recov=1, saturating at 2^CntW-1. It is cleared only by reset. Several bits set in one cycle count as one.
- Undefined: no counter flops are built and err_cnt_o is tied to 0.

Test Plan:
1. Reset release, no errors -> all outputs 0 for 20 cycles; ack toggling in Idle produces no req.
2. err_update_i=8'h04 for 1 cycle -> next cycle update_status_o=8'h04, first_idx_o=2, first_valid_o=1, recov_alert_req_o=1. Hold ack low 5 cycles: req stays 1. Raise ack: req=0 next cycle. Drop ack: Idle. Then clr_we_i=1, clr_wd_i=8'h04 -> status 0, first_valid_o=0.
3. During Req, pulse err_update_i=8'h01 and then 8'h80 -> exactly one additional req after ack handshake completes; update_status_o=8'h85.
4. err_storage_i=8'h10 -> fatal_alert_o=1 and storage_status_o=8'h10 next cycle; a clr_we_i with clr_wd_i=8'hFF does not clear either. Only assert rst_ni clears them.
5. Same-cycle clr_we_i with clr_wd_i=8'h02 and err_update_i=8'h02 on a set bit -> bit stays 1. Same-cycle errors on bits 3 and 6 -> first_idx_o=3.
6. With REG_SHADOW_ERR_CNT_EN, CntW=4: 20 single-cycle update errors -> err_cnt_o saturates at 15. Without the macro -> err_cnt_o=0.
